// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared widths and load-queue entry type for the writeback arbiter
package wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
        logic                  live;
    } wb_entry_t;
endpackage

// File: rtl/wb_load_queue.sv
// rtl/wb_load_queue.sv - in-order load result FIFO with squash-by-rd and pending-destination mask
module wb_load_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_push,
    input  wb_entry_t             i_push_entry,
    input  logic                  i_pop,
    input  logic                  i_squash_valid,
    input  logic [REG_ADDR_W-1:0] i_squash_rd,
    output wb_entry_t             o_head,
    output logic                  o_empty,
    output logic                  o_full,
    output logic [REG_COUNT-1:0]  o_pending_mask
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W+1)'(DEPTH);

    wb_entry_t        r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [PTR_W:0]   r_count;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].live <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i_squash_valid && (r_mem[i].rd == i_squash_rd)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            // Popped slots drop their live bit so the mask can scan every slot blindly.
            if (i_pop) begin
                r_mem[r_head].live <= 1'b0;
                r_head             <= r_head + 1'b1;
            end
            if (i_push) begin
                r_mem[r_tail] <= i_push_entry;
                r_tail        <= r_tail + 1'b1;
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head  = r_mem[r_head];
    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == FULL_COUNT);

    always_comb begin
        o_pending_mask = '0;
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (r_mem[i].live) begin
                    o_pending_mask[r_mem[i].rd] = 1'b1;
                end
            end
        end
        o_pending_mask[0] = 1'b0;
    end
endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and load results onto the single register-file write port
module writeback_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int XLEN  = wb_pkg::XLEN
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  i_alu_valid,
    input  logic [REG_ADDR_W-1:0] i_alu_rd,
    input  logic [XLEN-1:0]       i_alu_data,
    input  logic                  i_load_valid,
    output logic                  o_load_ready,
    input  logic [REG_ADDR_W-1:0] i_load_rd,
    input  logic [XLEN-1:0]       i_load_data,
    output logic                  o_rf_write_enable,
    output logic [REG_ADDR_W-1:0] o_rf_addr_rd,
    output logic [XLEN-1:0]       o_rf_data_rd,
    output logic [REG_COUNT-1:0]  o_pending_mask
);
    wb_entry_t w_head;
    wb_entry_t w_push_entry;
    logic      w_empty;
    logic      w_full;
    logic      w_load_fire;
    logic      w_alu_write;
    logic      w_squash_hit;
    logic      w_head_pop;
    logic      w_head_write;
    logic      w_bypass;
    logic      w_discard;
    logic      w_push;

    logic                  r_rf_write_enable;
    logic [REG_ADDR_W-1:0] r_rf_addr_rd;
    logic [XLEN-1:0]       r_rf_data_rd;

    assign o_load_ready = !reset && !w_full;
    assign w_load_fire  = i_load_valid && o_load_ready;
    assign w_alu_write  = i_alu_valid && (i_alu_rd != '0);

    // A same-cycle load to the ALU's rd is older, so its value is dead on arrival.
    assign w_squash_hit = w_alu_write && w_load_fire && (i_load_rd == i_alu_rd);

    // Dead heads drain even under ALU traffic; live heads wait for a free slot.
    assign w_head_pop   = !w_empty && (!w_head.live || !i_alu_valid);
    assign w_head_write = w_head_pop && w_head.live;
    assign w_bypass     = w_load_fire && w_empty && !i_alu_valid && (i_load_rd != '0);
    assign w_discard    = w_empty && w_squash_hit;
    assign w_push       = w_load_fire && !w_bypass && !w_discard;

    assign w_push_entry = '{rd: i_load_rd, data: i_load_data,
                            live: !w_squash_hit && (i_load_rd != '0)};

    wb_load_queue #(.DEPTH(DEPTH)) u_load_queue (
        .clock          (clock),
        .reset          (reset),
        .i_push         (w_push),
        .i_push_entry   (w_push_entry),
        .i_pop          (w_head_pop),
        .i_squash_valid (w_alu_write),
        .i_squash_rd    (i_alu_rd),
        .o_head         (w_head),
        .o_empty        (w_empty),
        .o_full         (w_full),
        .o_pending_mask (o_pending_mask)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rf_write_enable <= 1'b0;
            r_rf_addr_rd      <= '0;
            r_rf_data_rd      <= '0;
        end else begin
            r_rf_write_enable <= w_alu_write || w_head_write || w_bypass;
            if (w_alu_write) begin
                r_rf_addr_rd <= i_alu_rd;
                r_rf_data_rd <= i_alu_data;
            end else if (w_head_write) begin
                r_rf_addr_rd <= w_head.rd;
                r_rf_data_rd <= w_head.data;
            end else if (w_bypass) begin
                r_rf_addr_rd <= i_load_rd;
                r_rf_data_rd <= i_load_data;
            end
        end
    end

    assign o_rf_write_enable = r_rf_write_enable;
    assign o_rf_addr_rd      = r_rf_addr_rd;
    assign o_rf_data_rd      = r_rf_data_rd;
endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - directed and randomized self-checking bench for writeback_arbiter
module tb_writeback_arbiter;
    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        rst;
    logic        av;
    logic [4:0]  ard;
    logic [31:0] ad;
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        o_load_ready;
    logic        o_rf_write_enable;
    logic [4:0]  o_rf_addr_rd;
    logic [31:0] o_rf_data_rd;
    logic [31:0] o_pending_mask;

    always #5 clock = ~clock;

    writeback_arbiter #(.DEPTH(DEPTH), .XLEN(32)) dut (
        .clock             (clock),
        .reset             (rst),
        .i_alu_valid       (av),
        .i_alu_rd          (ard),
        .i_alu_data        (ad),
        .i_load_valid      (lv),
        .o_load_ready      (o_load_ready),
        .i_load_rd         (lrd),
        .i_load_data       (ld),
        .o_rf_write_enable (o_rf_write_enable),
        .o_rf_addr_rd      (o_rf_addr_rd),
        .o_rf_data_rd      (o_rf_data_rd),
        .o_pending_mask    (o_pending_mask)
    );

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        mq[$];
    bit          exp_we;
    logic [4:0]  exp_addr;
    logic [31:0] exp_data;
    bit          last_fire;
    int          checks = 0;
    int          fails  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock: check combinational outputs mid-low-phase, advance the model, check registered outputs.
    task automatic tick();
        bit          ready_e;
        bit          was_empty;
        bit          hit;
        logic [31:0] mask_e;
        ent_t        e;
        @(negedge clock);
        #1;
        ready_e = !rst && (mq.size() < DEPTH);
        mask_e  = '0;
        if (!rst) foreach (mq[i]) if (mq[i].live && mq[i].rd != 0) mask_e[mq[i].rd] = 1'b1;
        check("load_ready", {31'd0, o_load_ready}, {31'd0, ready_e});
        check("pending_mask", o_pending_mask, mask_e);
        last_fire = lv && ready_e;
        exp_we = 1'b0;
        if (rst) begin
            mq.delete();
            exp_addr = '0;
            exp_data = '0;
        end else begin
            was_empty = (mq.size() == 0);
            if (av && ard != 0) begin
                exp_we = 1'b1; exp_addr = ard; exp_data = ad;
            end
            if (!was_empty && (!mq[0].live || !av)) begin
                if (mq[0].live) begin
                    exp_we = 1'b1; exp_addr = mq[0].rd; exp_data = mq[0].data;
                end
                void'(mq.pop_front());
            end
            if (av && ard != 0) foreach (mq[i]) if (mq[i].rd == ard) mq[i].live = 1'b0;
            if (last_fire) begin
                hit = av && ard != 0 && lrd == ard;
                if (was_empty && !av && lrd != 0) begin
                    exp_we = 1'b1; exp_addr = lrd; exp_data = ld;
                end else if (!(was_empty && hit)) begin
                    e.rd = lrd; e.data = ld; e.live = !hit && lrd != 0;
                    mq.push_back(e);
                end
            end
        end
        @(posedge clock);
        #1;
        check("rf_write_enable", {31'd0, o_rf_write_enable}, {31'd0, exp_we});
        if (exp_we || rst) begin
            check("rf_addr_rd", {27'd0, o_rf_addr_rd}, {27'd0, exp_addr});
            check("rf_data_rd", o_rf_data_rd, exp_data);
        end
    endtask

    initial begin
        logic [4:0] rd_pool [5];
        int         n;
        rd_pool = '{5'd0, 5'd1, 5'd2, 5'd9, 5'd17};
        rst = 1'b1; av = 1'b0; ard = '0; ad = '0; lv = 1'b0; lrd = '0; ld = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();

        // ALU only
        av = 1'b1; ard = 5'd5; ad = 32'h1234;
        tick();
        check("alu_only_data", o_rf_data_rd, 32'h1234);
        av = 1'b0;

        // Load bypass on an empty queue
        lv = 1'b1; lrd = 5'd7; ld = 32'hCAFE;
        tick();
        check("bypass_addr", {27'd0, o_rf_addr_rd}, 32'd7);
        check("bypass_mask", o_pending_mask, 32'd0);
        lv = 1'b0;
        tick();

        // Contention: ALU every cycle while loads pile up
        av = 1'b1; ard = 5'd1; ad = 32'hA1; lv = 1'b1; n = 0;
        for (int c = 0; c < 7; c++) begin
            lrd = 5'(10 + n); ld = 32'h100 + 32'(n);
            tick();
            if (last_fire) n++;
        end
        check("fill_mask", o_pending_mask, 32'h0000_3C00);
        check("fill_ready", {31'd0, o_load_ready}, 32'd0);
        av = 1'b0;
        for (int c = 0; c < 6 && lv; c++) begin
            tick();
            if (last_fire) lv = 1'b0;
        end
        check("held_load_taken", {31'd0, lv}, 32'd0);
        repeat (5) tick();

        // Squash of a queued load, then same-cycle squash
        av = 1'b1; ard = 5'd2; ad = 32'h22; lv = 1'b1; lrd = 5'd9; ld = 32'h99;
        tick();
        lv = 1'b0; ard = 5'd9; ad = 32'h55;
        tick();
        check("squash_mask", o_pending_mask, 32'd0);
        av = 1'b0;
        repeat (2) tick();
        av = 1'b1; ard = 5'd9; ad = 32'h56; lv = 1'b1; lrd = 5'd9; ld = 32'h98;
        tick();
        av = 1'b0; lv = 1'b0;
        repeat (2) tick();

        // x0 from both sources
        av = 1'b1; ard = 5'd0; ad = 32'hDEAD; lv = 1'b1; lrd = 5'd0; ld = 32'hBEEF;
        tick();
        av = 1'b0; lv = 1'b0;
        repeat (2) tick();

        // Reset with three loads queued
        av = 1'b1; ard = 5'd3; ad = 32'h33; lv = 1'b1;
        for (int c = 0; c < 3; c++) begin
            lrd = 5'(20 + c); ld = 32'h200 + 32'(c);
            tick();
        end
        av = 1'b0; lv = 1'b0; rst = 1'b1;
        tick();
        check("reset_we", {31'd0, o_rf_write_enable}, 32'd0);
        rst = 1'b0;
        repeat (3) tick();

        // Randomized traffic with the producer holding any refused load
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            av  = ($urandom_range(0, 1) == 1);
            ard = rd_pool[$urandom_range(0, 4)];
            ad  = $urandom;
            if (!(lv && !last_fire)) begin
                lv  = ($urandom_range(0, 2) != 0);
                lrd = rd_pool[$urandom_range(0, 4)];
                ld  = $urandom;
            end
            tick();
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Single-writer front end for the integer register file. It merges same-cycle ALU results and data-memory load results onto the register file's one write port. ALU results take priority. Load results are buffered in a small in-order queue and drained on cycles when the ALU does not write. It also exposes a pending-destination mask so the hazard logic can stall reads of registers whose load value has not yet been written.

## Interface
Parameters:
- DEPTH, 4: load-queue entries; power of two, at least 2.
- XLEN, 32: data width.

Ports:
- clock  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- alu_valid  in  1  ALU result valid this cycle; never stalled.
- alu_rd  in  5  ALU destination register.
- alu_data  in  XLEN  ALU result.
- load_valid  in  1  load result offered.
- load_ready  out  1  load queue can accept; load transfers when load_valid && load_ready.
- load_rd  in  5  load destination register.
- load_data  in  XLEN  loaded value, already sign/zero extended.
- rf_write_enable  out  1  register-file write strobe (registered).
- rf_addr_rd  out  5  register-file write address (registered).
- rf_data_rd  out  XLEN  register-file write data (registered).
- pending_mask  out  32  bit i set when a live queued load targets xi; bit 0 is always 0.

## Operation
- Queue: circular FIFO with DEPTH entries of {rd, data, live}, with head/tail pointers and a count from 0 to DEPTH.
- load_ready = !reset && (count != DEPTH). A full queue does not accept a load, even on a cycle where it pops.
- Each cycle the output source is selected in this priority order:
  1. alu_valid: write the ALU result.
  2. The queue head is live: write the head and pop it.
  3. The queue is empty and a load transfers: bypass the load straight to the output without enqueuing it.
  4. Otherwise: no write.
- A queue head whose live bit is 0 is popped silently in any cycle, including ALU cycles. It never produces a write.
- Squash: an ALU write to rd X (X != 0) clears the live bit of every queued entry with rd X.
  - A load transferring in the same cycle with rd X is treated as older than the ALU write. It is enqueued with live = 0, or discarded if it would have taken the bypass path.
- rd = 0: never asserts rf_write_enable.
  - An ALU write to x0 produces no write.
  - A load to x0 is accepted and enqueued with live = 0.
- A load that transfers and neither bypasses nor is discarded is pushed at the tail. Push and pop in the same cycle leave count unchanged.
- pending_mask is combinational over the live entries currently in the queue. Bypassed loads never appear in it.

## Timing
- Output registers load on the clock edge. A write selected in cycle N is presented on rf_* during cycle N+1. The register file commits it at the end of N+1.
- Latency:
  - ALU result: 1 cycle.
  - Bypassed load: 1 cycle.
  - Queued load: 1 cycle after it reaches the head with no ALU write in that cycle.
- With continuous ALU traffic the queue does not drain. load_ready falls once DEPTH loads are held, and the producer must hold load_valid, load_rd and load_data stable until the transfer.
- Reset, including mid-operation:
  - count = 0, head = tail = 0, all live bits = 0.
  - rf_write_enable = 0, rf_addr_rd = 0, rf_data_rd = 0.
  - load_ready = 0 while reset is high; pending_mask = 0.
  - Queued loads are lost.
- Pointers wrap modulo DEPTH. Full and empty are distinguished by count, not by pointer equality.

## Structure
- Shared package wb_pkg holds XLEN, REG_ADDR_W = 5, REG_COUNT = 32 and the queue-entry typedef {rd, data, live}.
- One sub-module, wb_load_queue, contains the FIFO storage, pointers, count, the squash-by-rd port and the pending_mask generation.
- The top level contains the priority select, the bypass path and the output registers.

## Test plan
- ALU only: alu_valid with rd = 5 and data 0x1234 in cycle 0 gives rf_write_enable = 1, rf_addr_rd = 5, rf_data_rd = 0x1234 in cycle 1.
- Load bypass: queue empty, no ALU, load rd = 7 with data 0xCAFE. The load writes x7 one cycle later, and pending_mask stays 0.
- Contention and fill:
  - Stimulus: hold alu_valid with rd = 1 while offering loads to rd 10, 11, 12, 13, then a fifth load to rd 14.
  - Required: load_ready drops after 4 transfers, and pending_mask = bits 10 to 13.
  - Then drop alu_valid. Writes follow to x10, x11, x12, x13 on consecutive cycles, then the held load to x14.
- Squash:
  - Stimulus: queue a load to rd 9, then issue an ALU write to x9 = 0x55.
  - Required: pending_mask bit 9 clears, only the ALU write to x9 occurs, and the dead entry pops with no write.
  - Also required: a load and an ALU write to rd 9 in the same cycle produce only the ALU write.
- x0 handling: an ALU write and a load both targeting rd = 0 never raise rf_write_enable, and the queue still drains.
- Reset mid-operation: assert reset with 3 entries queued. In the next cycle all outputs are 0 and load_ready is 0. After release, load_ready = 1 and no stale writes occur.
